// File: rtl/singles_word_serializer.sv
// singles_word_serializer
// Takes 128-bit single-event words from the detector over ready/valid, checks
// their framing, and sends good words as eight 16-bit beats, most-significant
// half-word first. Malformed words are dropped and counted. A one-word holding
// register refills the shift register on the last beat, so back-to-back frames
// go out at one beat per clock.
//
// Ports
//   clk, rst    clock, asynchronous active-high reset
//   in_valid    detector word available
//   in_data     detector word: [127:123] framing, [122] single, [121:116] block_id,
//               [115:20] energy, [19:0] time
//   in_ready    holding register empty (registered)
//   out_valid   beat valid
//   out_data    beat payload
//   out_last    final beat of a frame
//   out_ready   downstream accepts beat
//   frame_err   one-cycle pulse per dropped word
//   nframes     frames fully sent (wraps)
//   nerrors     dropped words (saturates at 0xFFFF)
module singles_word_serializer #(
    parameter int unsigned DATA_BITS = 128,
    parameter int unsigned OUT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [OUT_BITS-1:0]  out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic [31:0]          nframes,
    output logic [15:0]          nerrors
);

    localparam int unsigned BEAT_W  = 3;
    localparam int unsigned FRAME_W = 5;
    localparam logic [BEAT_W-1:0]  LAST_BEAT  = 3'd7;
    localparam logic [FRAME_W-1:0] FRAME_GOOD = 5'b11111;
    localparam logic [15:0]        ERR_MAX    = 16'hFFFF;

    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic                 busy_q, busy_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_last_q, out_last_d;
    logic                 frame_err_q, frame_err_d;
    logic [31:0]          nframes_q, nframes_d;
    logic [15:0]          nerrors_q, nerrors_d;

    logic accept_c, beat_acc_c, last_acc_c, xfer_c, frame_ok_c;

    // Handshake and transfer conditions
    always_comb begin
        accept_c   = in_valid & in_ready_q;
        beat_acc_c = busy_q & out_ready;
        last_acc_c = beat_acc_c & (beat_q == LAST_BEAT);
        xfer_c     = hold_full_q & (~busy_q | last_acc_c);
        frame_ok_c = (hold_q[DATA_BITS-1 -: FRAME_W] == FRAME_GOOD);
    end

    // Next-state logic
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        beat_d      = beat_q;
        busy_d      = busy_q;
        nframes_d   = nframes_q;
        nerrors_d   = nerrors_q;
        frame_err_d = 1'b0;

        // Holding register: a transfer empties it unless a new word lands the same cycle
        if (xfer_c) begin
            hold_full_d = 1'b0;
        end
        if (accept_c) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        // Beat progress; the buffer shifts so the current beat is always at the top
        if (beat_acc_c) begin
            beat_d  = beat_q + 3'd1;
            shreg_d = {shreg_q[DATA_BITS-OUT_BITS-1:0], OUT_BITS'(0)};
        end
        if (last_acc_c) begin
            busy_d    = 1'b0;
            nframes_d = nframes_q + 32'd1;
        end

        // Transfer: good words reload the shifter, bad words are only counted
        if (xfer_c) begin
            if (frame_ok_c) begin
                shreg_d = hold_q;
                beat_d  = '0;
                busy_d  = 1'b1;
            end else begin
                frame_err_d = 1'b1;
                if (nerrors_q != ERR_MAX) begin
                    nerrors_d = nerrors_q + 16'd1;
                end
            end
        end

        in_ready_d = ~hold_full_d;
        out_last_d = busy_d & (beat_d == LAST_BEAT);
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            beat_q      <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
            nframes_q   <= '0;
            nerrors_q   <= '0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            beat_q      <= beat_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
            nframes_q   <= nframes_d;
            nerrors_q   <= nerrors_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = busy_q;
    assign out_data  = shreg_q[DATA_BITS-1 -: OUT_BITS];
    assign out_last  = out_last_q;
    assign frame_err = frame_err_q;
    assign nframes   = nframes_q;
    assign nerrors   = nerrors_q;

endmodule

// File: tb/tb_singles_word_serializer.sv
// Testbench for singles_word_serializer: drives words and downstream ready from
// one process on the falling edge and checks beats against a queue-based model.
module tb_singles_word_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [15:0]  out_data;
    logic         out_last;
    logic         out_ready;
    logic         frame_err;
    logic [31:0]  nframes;
    logic [15:0]  nerrors;

    singles_word_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .nframes   (nframes),
        .nerrors   (nerrors)
    );

    always #5 clk = ~clk;

    // Reference model: expected beats in order, expected counters
    logic [15:0] exp_beat_q[$];
    bit          exp_last_q[$];
    int          exp_frames;
    int          exp_errs;
    int          ferr_seen;

    int  checks;
    int  errors;
    int  cyc;
    bit  rnd_ready;
    bit  prev_stall;
    logic [15:0] prev_data;
    logic prev_last;
    bit  prev_acc;
    int  first_beat;
    int  last_beat;
    int  acc_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // A good word becomes eight MS-first beats; a bad one only bumps the error count
    task automatic model_accept(input logic [127:0] w);
        if (w[127:123] == 5'b11111) begin
            for (int i = 0; i < 8; i++) begin
                exp_beat_q.push_back(w[127 - 16*i -: 16]);
                exp_last_q.push_back(i == 7);
            end
        end else if (exp_errs < 65535) begin
            exp_errs++;
        end
    endtask

    // One clock: inputs already set for the coming rising edge; check, then advance
    task automatic cycle();
        logic [15:0] eb;
        bit          el;
        if (rnd_ready) out_ready = ($urandom_range(0, 99) < 30);
        if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(prev_data));
            check("stall_last", 32'(out_last), 32'(prev_last));
        end
        if (prev_acc) check("in_ready_after_accept", 32'(in_ready), 32'd0);
        if (frame_err) ferr_seen++;
        if (out_valid && out_ready) begin
            if (exp_beat_q.size() == 0) begin
                check("unexpected_beat", 32'(out_data), 32'(exp_beat_q.size()) + 32'h10000);
            end else begin
                eb = exp_beat_q.pop_front();
                el = exp_last_q.pop_front();
                check("beat_data", 32'(out_data), 32'(eb));
                check("beat_last", 32'(out_last), 32'(el));
                if (el) exp_frames++;
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
            end
        end
        prev_stall = out_valid & ~out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        prev_acc   = in_valid & in_ready;
        if (in_valid && in_ready) model_accept(in_data);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [127:0] w);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 2000 && !done; k++) begin
            if (in_ready) begin
                acc_cyc = cyc;
                done = 1;
            end
            cycle();
        end
        in_valid = 1'b0;
        check("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && exp_beat_q.size() > 0; k++) cycle();
        for (int k = 0; k < 3; k++) cycle();
        check("drain_left", 32'(exp_beat_q.size()), 32'd0);
    endtask

    function automatic logic [127:0] rand_good();
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        w[127:123] = 5'b11111;
        return w;
    endfunction

    initial begin
        int ferr0;
        checks = 0; errors = 0; cyc = 0;
        exp_frames = 0; exp_errs = 0; ferr_seen = 0;
        rnd_ready = 0; prev_stall = 0; prev_acc = 0;
        prev_data = '0; prev_last = 0;
        first_beat = -1; last_beat = -1; acc_cyc = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);

        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_nframes", nframes, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Single good word: latency and contiguous beats
        first_beat = -1;
        send_word(128'hF8C0_0000_0000_0000_0000_0000_0001_2345);
        drain(100);
        check("t1_latency", 32'(first_beat - acc_cyc), 32'd2);
        check("t1_span", 32'(last_beat - first_beat), 32'd7);
        check("t1_nframes", nframes, 32'd1);

        // Three back-to-back words: 24 beats without a bubble
        first_beat = -1;
        for (int i = 0; i < 3; i++) send_word(rand_good());
        drain(200);
        check("t2_span", 32'(last_beat - first_beat), 32'd23);
        check("t2_nframes", nframes, 32'(exp_frames));

        // Bad framing followed by a good word
        ferr0 = ferr_seen;
        send_word({8'h78, 120'd0});
        send_word(rand_good());
        drain(200);
        check("t3_frame_err", 32'(ferr_seen - ferr0), 32'd1);
        check("t3_nerrors", 32'(nerrors), 32'(exp_errs));
        check("t3_nframes", nframes, 32'(exp_frames));

        // Random 30% downstream ready, 50 good words with random gaps
        rnd_ready = 1;
        for (int i = 0; i < 50; i++) begin
            if ($urandom_range(0, 3) == 0) cycle();
            send_word(rand_good());
        end
        drain(10000);
        rnd_ready = 0;
        out_ready = 1'b1;
        cycle();
        check("t4_nframes", nframes, 32'(exp_frames));

        // Reset in the middle of a frame (beat 4 on the output)
        send_word(rand_good());
        for (int k = 0; k < 50 && exp_beat_q.size() > 4; k++) cycle();
        check("t5_at_beat4", 32'(exp_beat_q.size()), 32'd4);
        rst = 1'b1;
        #1;
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_out_data", 32'(out_data), 32'd0);
        check("t5_out_last", 32'(out_last), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd0);
        check("t5_nframes", nframes, 32'd0);
        check("t5_nerrors", 32'(nerrors), 32'd0);
        check("t5_frame_err", 32'(frame_err), 32'd0);
        exp_beat_q.delete();
        exp_last_q.delete();
        exp_frames = 0; exp_errs = 0;
        prev_stall = 0; prev_acc = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_in_ready_held", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("t5_in_ready_rise", 32'(in_ready), 32'd1);
        first_beat = -1;
        send_word(128'hF8C0_0000_0000_0000_0000_0000_0001_2345);
        drain(100);
        check("t5_latency", 32'(first_beat - acc_cyc), 32'd2);
        check("t5_nframes", nframes, 32'd1);

        // Error counter saturation
        force dut.nerrors_q = 16'hFFFE;
        @(negedge clk);
        release dut.nerrors_q;
        cycle();
        check("t6_preload", 32'(nerrors), 32'h0000FFFE);
        exp_errs = 65534;
        ferr0 = ferr_seen;
        for (int i = 0; i < 3; i++) send_word({5'b01010, 123'(i)});
        drain(50);
        check("t6_nerrors", 32'(nerrors), 32'(exp_errs));
        check("t6_frame_err", 32'(ferr_seen - ferr0), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
